// File: rtl/mac_mouse_pkg.sv
// rtl/mac_mouse_pkg.sv - shared constants and types for the PS/2-to-quadrature mouse bridge
package mac_mouse_pkg;

  // Bit positions on the macplus MOUSE bus
  localparam int X1  = 0;
  localparam int X2  = 1;
  localparam int Y1  = 2;
  localparam int Y2  = 3;
  localparam int BTN = 4;

  // Quadrature pattern per phase, packed as {Q2,Q1} in 2-bit slots, phase 0 in the low slot.
  // Phase 0..3 gives (Q1,Q2) = 00, 01, 11, 10.
  localparam logic [7:0] GRAY_LUT = 8'b01_11_10_00;

  // Packet assembler byte position
  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } asm_state_t;

endpackage

// File: rtl/mouse_quad_axis.sv
// rtl/mouse_quad_axis.sv - one motion axis: saturating accumulator, phase counter, quadrature encode
module mouse_quad_axis
  import mac_mouse_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              tick,
  input  logic              apply,
  input  logic signed [8:0] delta,
  output logic [1:0]        q
);

  localparam logic signed [ACC_W:0] SUM_MAX = (ACC_W+1)'((1 << (ACC_W-1)) - 1);
  localparam logic signed [ACC_W:0] SUM_MIN = -SUM_MAX;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]              phase_q, phase_d;
  logic signed [ACC_W:0]   acc_ext, dlt_ext, stp_ext, sum;
  logic                    step_up, step_dn;

  // Step direction comes from the pre-update accumulator; new motion and the step land together
  always_comb begin
    step_up = tick && !acc_q[ACC_W-1] && (acc_q != '0);
    step_dn = tick && acc_q[ACC_W-1];
    acc_ext = {acc_q[ACC_W-1], acc_q};
    dlt_ext = apply ? {{(ACC_W-8){delta[8]}}, delta} : '0;
    stp_ext = step_up ? (ACC_W+1)'(1) : (step_dn ? {(ACC_W+1){1'b1}} : '0);
    sum     = acc_ext + dlt_ext - stp_ext;
    if (sum > SUM_MAX) begin
      acc_d = SUM_MAX[ACC_W-1:0];
    end else if (sum < SUM_MIN) begin
      acc_d = SUM_MIN[ACC_W-1:0];
    end else begin
      acc_d = sum[ACC_W-1:0];
    end
    phase_d = phase_q;
    if (step_up) begin
      phase_d = phase_q + 2'd1;
    end else if (step_dn) begin
      phase_d = phase_q - 2'd1;
    end
  end

  // Accumulator and phase registers
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      acc_q   <= '0;
      phase_q <= 2'd0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
    end
  end

  // Gray encode of the current phase, {Q2,Q1}
  always_comb begin
    q = GRAY_LUT[{phase_q, 1'b0} +: 2];
  end

endmodule

// File: rtl/mouse_quad.sv
// rtl/mouse_quad.sv - PS/2 mouse packet assembler driving the macplus quadrature/button bus
module mouse_quad
  import mac_mouse_pkg::*;
#(
  parameter int STEP_DIV = 2000,
  parameter int ACC_W    = 10,
  parameter int TIMEOUT  = 1000000
) (
  input  logic       clk_sys,
  input  logic       RESET,
  input  logic [7:0] byte_in,
  input  logic       byte_strobe,
  output logic [5:0] mouse,
  output logic       pkt_err,
  output logic       pkt_done
);

  localparam int PRE_W = $clog2(STEP_DIV);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(STEP_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  asm_state_t        state_q, state_d;
  logic [7:0]        hdr_q, hdr_d;
  logic [7:0]        dx_lo_q, dx_lo_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              btn_n_q, btn_n_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              apply, tick;
  logic signed [8:0] dx, dy, dy_mac;
  logic [1:0]        qx, qy;
  logic              unused_hdr;

  assign unused_hdr = ^hdr_q[3:1];

  // Packet assembly, inter-byte timeout and button capture
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    dx_lo_d = dx_lo_q;
    tmo_d   = tmo_q;
    btn_n_d = btn_n_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    apply   = 1'b0;
    case (state_q)
      B1, B2: begin
        if (tmo_q == TMO_MAX) begin
          state_d = B0;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else if (byte_strobe) begin
          tmo_d = '0;
          if (state_q == B1) begin
            dx_lo_d = byte_in;
            state_d = B2;
          end else begin
            apply   = 1'b1;
            done_d  = 1'b1;
            btn_n_d = ~hdr_q[0];
            state_d = B0;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        tmo_d = '0;
        if (byte_strobe) begin
          if (byte_in[3]) begin
            hdr_d   = byte_in;
            state_d = B1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

  // Free-running step prescaler
  always_comb begin
    tick  = (pre_q == PRE_MAX);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // Motion decode; Mac Y grows downward so the Y axis takes -dy (dy=-256 clips to +255)
  always_comb begin
    dx     = hdr_q[6] ? 9'sd0 : $signed({hdr_q[4], dx_lo_q});
    dy     = hdr_q[7] ? 9'sd0 : $signed({hdr_q[5], byte_in});
    dy_mac = (dy == -9'sd256) ? 9'sd255 : -dy;
  end

  // Assembler, prescaler and output pulse registers
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q <= B0;
      hdr_q   <= 8'h00;
      dx_lo_q <= 8'h00;
      tmo_q   <= '0;
      pre_q   <= '0;
      btn_n_q <= 1'b1;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      dx_lo_q <= dx_lo_d;
      tmo_q   <= tmo_d;
      pre_q   <= pre_d;
      btn_n_q <= btn_n_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  mouse_quad_axis #(.ACC_W(ACC_W)) u_x (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .tick    (tick),
    .apply   (apply),
    .delta   (dx),
    .q       (qx)
  );

  mouse_quad_axis #(.ACC_W(ACC_W)) u_y (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .tick    (tick),
    .apply   (apply),
    .delta   (dy_mac),
    .q       (qy)
  );

  // Output bus assembly
  always_comb begin
    mouse      = 6'b000000;
    mouse[X1]  = qx[0];
    mouse[X2]  = qx[1];
    mouse[Y1]  = qy[0];
    mouse[Y2]  = qy[1];
    mouse[BTN] = btn_n_q;
    pkt_err    = err_q;
    pkt_done   = done_q;
  end

endmodule
